// File: rtl/dma_rd_arb_pkg.sv
// Shared definitions for the DMA read-descriptor arbiter slice.
//
// Contents:
//   SRC_CU / SRC_RE  source IDs, also the MSB of every tag on the DMA side
//   STS_ERR_W        width of the DMA read status error field
//   desc_state_e     state of the descriptor output register (EMPTY / FULL)
//
// Build option: DMA_RD_ARB_LIMIT_EN (see dma_rd_outstanding_cnt).
package dma_rd_arb_pkg;

  localparam logic SRC_CU = 1'b0;
  localparam logic SRC_RE = 1'b1;

  localparam int STS_ERR_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } desc_state_e;

endpackage

// File: rtl/dma_rd_outstanding_cnt.sv
// Per-source in-flight descriptor counter.
//
// Build option: DMA_RD_ARB_LIMIT_EN
//   defined   -> below_limit_o reflects the MAX_OUTSTANDING limit
//   undefined -> below_limit_o is constant 1 (the count is still tracked)
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   inc_i          a descriptor of this source was accepted downstream
//   dec_i          a read status for this source arrived
//   hold_i         a descriptor of this source sits in the output register
//                  and has not been counted yet
//   count_o        descriptors in flight (saturates at MAX_OUTSTANDING)
//   below_limit_o  this source may be granted another descriptor
//   underflow_o    sticky: a status arrived while the count was zero
module dma_rd_outstanding_cnt
  import dma_rd_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] count_o,
  output logic             below_limit_o,
  output logic             underflow_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;

  // A simultaneous increment and decrement cancel out. A decrement at zero
  // leaves the count alone and raises the sticky underflow flag.
  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (inc_i && !dec_i) begin
      if (count_q != MAX_CNT) count_d = count_q + ONE;
    end else if (dec_i && !inc_i) begin
      if (count_q == '0) underflow_d = 1'b1;
      else               count_d     = count_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef DMA_RD_ARB_LIMIT_EN
  // The descriptor waiting in the output register is only counted once it
  // is accepted, so it is added here to keep the in-flight total honest.
  logic [CNT_W:0] in_flight;
  assign in_flight     = {1'b0, count_q} + {{CNT_W{1'b0}}, hold_i};
  assign below_limit_o = in_flight < {1'b0, MAX_CNT};
`else
  logic unused_hold;
  assign unused_hold   = hold_i;
  assign below_limit_o = 1'b1;
`endif

  assign count_o     = count_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/dma_rd_desc_arb.sv
// Round-robin arbiter sharing one DMA read-descriptor port between the
// compute unit (CU, source 0) and the RDMA engine (RE, source 1).
//
// Build option: DMA_RD_ARB_LIMIT_EN enables per-source outstanding limits.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_cu_desc_* / s_re_desc_* source descriptors (valid/ready handshake)
//   m_desc_*                 granted descriptor, tag = {source_id, tag}
//   sel_tag / sel_valid      source-select sideband for the write-data mux
//   sel_afull                write-mux tag FIFO almost full, blocks grants
//   s_sts_*                  DMA read status, tag MSB selects the source
//   m_cu_sts_* / m_re_sts_*  status routed back with the source bit stripped
//   cu_outstanding / re_outstanding  in-flight descriptor counts
//   sts_underflow            sticky: status for a source with none in flight
module dma_rd_desc_arb
  import dma_rd_arb_pkg::*;
#(
  parameter int DMA_ADDR_WIDTH  = 64,
  parameter int RAM_ADDR_WIDTH  = 15,
  parameter int LEN_WIDTH       = 16,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DMA_ADDR_WIDTH-1:0] s_cu_desc_dma_addr,
  input  logic [RAM_ADDR_WIDTH-1:0] s_cu_desc_ram_addr,
  input  logic [LEN_WIDTH-1:0]      s_cu_desc_len,
  input  logic [TAG_WIDTH-1:0]      s_cu_desc_tag,
  input  logic                      s_cu_desc_valid,
  output logic                      s_cu_desc_ready,
  input  logic [DMA_ADDR_WIDTH-1:0] s_re_desc_dma_addr,
  input  logic [RAM_ADDR_WIDTH-1:0] s_re_desc_ram_addr,
  input  logic [LEN_WIDTH-1:0]      s_re_desc_len,
  input  logic [TAG_WIDTH-1:0]      s_re_desc_tag,
  input  logic                      s_re_desc_valid,
  output logic                      s_re_desc_ready,
  output logic [DMA_ADDR_WIDTH-1:0] m_desc_dma_addr,
  output logic [RAM_ADDR_WIDTH-1:0] m_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]      m_desc_len,
  output logic [TAG_WIDTH:0]        m_desc_tag,
  output logic                      m_desc_valid,
  input  logic                      m_desc_ready,
  output logic                      sel_tag,
  output logic                      sel_valid,
  input  logic                      sel_afull,
  input  logic [TAG_WIDTH:0]        s_sts_tag,
  input  logic [STS_ERR_W-1:0]      s_sts_error,
  input  logic                      s_sts_valid,
  output logic [TAG_WIDTH-1:0]      m_cu_sts_tag,
  output logic [STS_ERR_W-1:0]      m_cu_sts_error,
  output logic                      m_cu_sts_valid,
  output logic [TAG_WIDTH-1:0]      m_re_sts_tag,
  output logic [STS_ERR_W-1:0]      m_re_sts_error,
  output logic                      m_re_sts_valid,
  output logic [CNT_W-1:0]          cu_outstanding,
  output logic [CNT_W-1:0]          re_outstanding,
  output logic                      sts_underflow
);

  desc_state_e               state_q;
  logic                      last_grant_q;
  logic [DMA_ADDR_WIDTH-1:0] dma_addr_q;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [TAG_WIDTH:0]        tag_q;

  logic cu_below_limit, re_below_limit;
  logic cu_underflow, re_underflow;

  // Arbitration happens when the output register is free or being drained
  // this cycle; a descriptor already held is never taken back by sel_afull.
  logic can_arb, cu_elig, re_elig, grant_cu, grant_re, grant_any, desc_accept;

  assign desc_accept = (state_q == ST_FULL) && m_desc_ready;
  assign can_arb     = ((state_q == ST_EMPTY) || m_desc_ready) && !sel_afull;
  assign cu_elig     = s_cu_desc_valid && cu_below_limit;
  assign re_elig     = s_re_desc_valid && re_below_limit;
  assign grant_cu    = can_arb && cu_elig && (!re_elig || last_grant_q == SRC_RE);
  assign grant_re    = can_arb && re_elig && (!cu_elig || last_grant_q == SRC_CU);
  assign grant_any   = grant_cu || grant_re;

  assign s_cu_desc_ready = grant_cu;
  assign s_re_desc_ready = grant_re;

  // Output register FSM: a grant always (re)loads, otherwise an accepted
  // descriptor empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= SRC_RE;
      dma_addr_q   <= '0;
      ram_addr_q   <= '0;
      len_q        <= '0;
      tag_q        <= '0;
    end else if (grant_any) begin
      state_q      <= ST_FULL;
      last_grant_q <= grant_re ? SRC_RE : SRC_CU;
      if (grant_re) begin
        dma_addr_q <= s_re_desc_dma_addr;
        ram_addr_q <= s_re_desc_ram_addr;
        len_q      <= s_re_desc_len;
        tag_q      <= {SRC_RE, s_re_desc_tag};
      end else begin
        dma_addr_q <= s_cu_desc_dma_addr;
        ram_addr_q <= s_cu_desc_ram_addr;
        len_q      <= s_cu_desc_len;
        tag_q      <= {SRC_CU, s_cu_desc_tag};
      end
    end else if (desc_accept) begin
      state_q <= ST_EMPTY;
    end
  end

  assign m_desc_dma_addr = dma_addr_q;
  assign m_desc_ram_addr = ram_addr_q;
  assign m_desc_len      = len_q;
  assign m_desc_tag      = tag_q;
  assign m_desc_valid    = (state_q == ST_FULL);
  assign sel_tag         = tag_q[TAG_WIDTH];
  assign sel_valid       = m_desc_valid;

  // Status return: one register stage, the tag MSB picks the destination.
  logic sts_to_cu, sts_to_re;
  assign sts_to_cu = s_sts_valid && (s_sts_tag[TAG_WIDTH] == SRC_CU);
  assign sts_to_re = s_sts_valid && (s_sts_tag[TAG_WIDTH] == SRC_RE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cu_sts_valid <= 1'b0;
      m_cu_sts_tag   <= '0;
      m_cu_sts_error <= '0;
      m_re_sts_valid <= 1'b0;
      m_re_sts_tag   <= '0;
      m_re_sts_error <= '0;
    end else begin
      m_cu_sts_valid <= sts_to_cu;
      m_re_sts_valid <= sts_to_re;
      if (sts_to_cu) begin
        m_cu_sts_tag   <= s_sts_tag[TAG_WIDTH-1:0];
        m_cu_sts_error <= s_sts_error;
      end
      if (sts_to_re) begin
        m_re_sts_tag   <= s_sts_tag[TAG_WIDTH-1:0];
        m_re_sts_error <= s_sts_error;
      end
    end
  end

  dma_rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cu_cnt (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (desc_accept && (tag_q[TAG_WIDTH] == SRC_CU)),
    .dec_i         (sts_to_cu),
    .hold_i        ((state_q == ST_FULL) && (tag_q[TAG_WIDTH] == SRC_CU)),
    .count_o       (cu_outstanding),
    .below_limit_o (cu_below_limit),
    .underflow_o   (cu_underflow)
  );

  dma_rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_re_cnt (
    .clk           (clk),
    .rst           (rst),
    .inc_i         (desc_accept && (tag_q[TAG_WIDTH] == SRC_RE)),
    .dec_i         (sts_to_re),
    .hold_i        ((state_q == ST_FULL) && (tag_q[TAG_WIDTH] == SRC_RE)),
    .count_o       (re_outstanding),
    .below_limit_o (re_below_limit),
    .underflow_o   (re_underflow)
  );

  assign sts_underflow = cu_underflow || re_underflow;

endmodule

// File: tb/tb_dma_rd_desc_arb.sv
// Directed testbench for dma_rd_desc_arb (default parameters).
// Expectations for the outstanding limit follow DMA_RD_ARB_LIMIT_EN.
module tb_dma_rd_desc_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_cu_desc_dma_addr, s_re_desc_dma_addr, m_desc_dma_addr;
  logic [14:0] s_cu_desc_ram_addr, s_re_desc_ram_addr, m_desc_ram_addr;
  logic [15:0] s_cu_desc_len, s_re_desc_len, m_desc_len;
  logic [7:0]  s_cu_desc_tag, s_re_desc_tag;
  logic        s_cu_desc_valid, s_cu_desc_ready, s_re_desc_valid, s_re_desc_ready;
  logic [8:0]  m_desc_tag;
  logic        m_desc_valid, m_desc_ready;
  logic        sel_tag, sel_valid, sel_afull;
  logic [8:0]  s_sts_tag;
  logic [3:0]  s_sts_error;
  logic        s_sts_valid;
  logic [7:0]  m_cu_sts_tag, m_re_sts_tag;
  logic [3:0]  m_cu_sts_error, m_re_sts_error;
  logic        m_cu_sts_valid, m_re_sts_valid;
  logic [4:0]  cu_outstanding, re_outstanding;
  logic        sts_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dma_rd_desc_arb dut (
    .clk(clk), .rst(rst),
    .s_cu_desc_dma_addr(s_cu_desc_dma_addr), .s_cu_desc_ram_addr(s_cu_desc_ram_addr),
    .s_cu_desc_len(s_cu_desc_len), .s_cu_desc_tag(s_cu_desc_tag),
    .s_cu_desc_valid(s_cu_desc_valid), .s_cu_desc_ready(s_cu_desc_ready),
    .s_re_desc_dma_addr(s_re_desc_dma_addr), .s_re_desc_ram_addr(s_re_desc_ram_addr),
    .s_re_desc_len(s_re_desc_len), .s_re_desc_tag(s_re_desc_tag),
    .s_re_desc_valid(s_re_desc_valid), .s_re_desc_ready(s_re_desc_ready),
    .m_desc_dma_addr(m_desc_dma_addr), .m_desc_ram_addr(m_desc_ram_addr),
    .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .sel_tag(sel_tag), .sel_valid(sel_valid), .sel_afull(sel_afull),
    .s_sts_tag(s_sts_tag), .s_sts_error(s_sts_error), .s_sts_valid(s_sts_valid),
    .m_cu_sts_tag(m_cu_sts_tag), .m_cu_sts_error(m_cu_sts_error),
    .m_cu_sts_valid(m_cu_sts_valid),
    .m_re_sts_tag(m_re_sts_tag), .m_re_sts_error(m_re_sts_error),
    .m_re_sts_valid(m_re_sts_valid),
    .cu_outstanding(cu_outstanding), .re_outstanding(re_outstanding),
    .sts_underflow(sts_underflow)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_cu_desc_dma_addr = '0; s_cu_desc_ram_addr = '0; s_cu_desc_len = '0;
    s_cu_desc_tag = '0; s_cu_desc_valid = 1'b0;
    s_re_desc_dma_addr = '0; s_re_desc_ram_addr = '0; s_re_desc_len = '0;
    s_re_desc_tag = '0; s_re_desc_valid = 1'b0;
    m_desc_ready = 1'b0; sel_afull = 1'b0;
    s_sts_tag = '0; s_sts_error = '0; s_sts_valid = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (m_desc_valid !== 1'b0 || sel_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got m_desc_valid=%b sel_valid=%b, want 0/0", m_desc_valid, sel_valid);
    end
    checks++;
    if (m_desc_tag !== 9'h000 || m_desc_dma_addr !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got tag=%h addr=%h, want 0", m_desc_tag, m_desc_dma_addr);
    end
    checks++;
    if (cu_outstanding !== 5'd0 || re_outstanding !== 5'd0 || sts_underflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cnt: got cu=%0d re=%0d uf=%b, want 0/0/0", cu_outstanding, re_outstanding, sts_underflow);
    end
    checks++;
    if (m_cu_sts_valid !== 1'b0 || m_re_sts_valid !== 1'b0 || s_cu_desc_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_sts: got cu_sts_v=%b re_sts_v=%b cu_rdy=%b, want 0", m_cu_sts_valid, m_re_sts_valid, s_cu_desc_ready);
    end
  endtask

  task automatic test_cu_stream();
    apply_reset();
    m_desc_ready = 1'b1;
    s_cu_desc_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_cu_desc_tag = 8'(i);
      s_cu_desc_dma_addr = 64'h1000 + 64'(i);
      #1;
      checks++;
      if (s_cu_desc_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL cu_ready_%0d: got %b, want 1", i, s_cu_desc_ready);
      end
      tick();
      checks++;
      if (m_desc_valid !== 1'b1 || m_desc_tag !== 9'(i) || sel_tag !== 1'b0
          || m_desc_dma_addr !== 64'h1000 + 64'(i)) begin
        failures++;
        $display("[TB] FAIL cu_desc_%0d: got v=%b tag=%h sel=%b addr=%h, want 1/%h/0/%h",
                 i, m_desc_valid, m_desc_tag, sel_tag, m_desc_dma_addr, 9'(i), 64'h1000 + 64'(i));
      end
    end
    s_cu_desc_valid = 1'b0;
    tick();
    checks++;
    if (cu_outstanding !== 5'd3 || m_desc_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cu_count: got cnt=%0d v=%b, want 3/0", cu_outstanding, m_desc_valid);
    end
    // Return the three completions with distinct errors.
    for (int i = 1; i <= 3; i++) begin
      s_sts_valid = 1'b1;
      s_sts_tag = 9'(i);
      s_sts_error = 4'(i + 4);
      tick();
      checks++;
      if (m_cu_sts_valid !== 1'b1 || m_re_sts_valid !== 1'b0
          || m_cu_sts_tag !== 8'(i) || m_cu_sts_error !== 4'(i + 4)) begin
        failures++;
        $display("[TB] FAIL cu_sts_%0d: got v=%b rev=%b tag=%h err=%h, want 1/0/%h/%h",
                 i, m_cu_sts_valid, m_re_sts_valid, m_cu_sts_tag, m_cu_sts_error, 8'(i), 4'(i + 4));
      end
    end
    s_sts_valid = 1'b0;
    tick();
    checks++;
    if (cu_outstanding !== 5'd0 || m_cu_sts_valid !== 1'b0 || sts_underflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cu_drain: got cnt=%0d sv=%b uf=%b, want 0/0/0", cu_outstanding, m_cu_sts_valid, sts_underflow);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp_tag [4];
    exp_tag[0] = 9'h010; exp_tag[1] = 9'h120; exp_tag[2] = 9'h010; exp_tag[3] = 9'h120;
    apply_reset();
    m_desc_ready = 1'b1;
    s_cu_desc_tag = 8'h10; s_re_desc_tag = 8'h20;
    s_cu_desc_valid = 1'b1; s_re_desc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (m_desc_valid !== 1'b1 || m_desc_tag !== exp_tag[i] || sel_tag !== exp_tag[i][8]) begin
        failures++;
        $display("[TB] FAIL rr_grant_%0d: got v=%b tag=%h sel=%b, want 1/%h/%b",
                 i, m_desc_valid, m_desc_tag, sel_tag, exp_tag[i], exp_tag[i][8]);
      end
    end
    s_cu_desc_valid = 1'b0; s_re_desc_valid = 1'b0;
    tick();
    checks++;
    if (cu_outstanding !== 5'd2 || re_outstanding !== 5'd2) begin
      failures++;
      $display("[TB] FAIL rr_counts: got cu=%0d re=%0d, want 2/2", cu_outstanding, re_outstanding);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    s_cu_desc_tag = 8'h07; s_cu_desc_len = 16'h0040; s_cu_desc_valid = 1'b1;
    tick();
    s_re_desc_tag = 8'h33; s_re_desc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (m_desc_valid !== 1'b1 || m_desc_tag !== 9'h007 || m_desc_len !== 16'h0040
          || sel_tag !== 1'b0 || s_cu_desc_ready !== 1'b0 || s_re_desc_ready !== 1'b0
          || cu_outstanding !== 5'd0) begin
        failures++;
        $display("[TB] FAIL hold_%0d: got v=%b tag=%h len=%h sel=%b rdy=%b%b cnt=%0d, want 1/007/0040/0/00/0",
                 i, m_desc_valid, m_desc_tag, m_desc_len, sel_tag, s_cu_desc_ready, s_re_desc_ready, cu_outstanding);
      end
      tick();
    end
    s_cu_desc_valid = 1'b0;
    m_desc_ready = 1'b1;
    #1;
    checks++;
    if (s_re_desc_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reload_ready: got %b, want 1", s_re_desc_ready);
    end
    tick();
    checks++;
    if (m_desc_tag !== 9'h133 || cu_outstanding !== 5'd1) begin
      failures++;
      $display("[TB] FAIL reload: got tag=%h cnt=%0d, want 133/1", m_desc_tag, cu_outstanding);
    end
    // Asynchronous reset drops the held descriptor without a clock edge.
    m_desc_ready = 1'b0;
    s_re_desc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (m_desc_valid !== 1'b0 || cu_outstanding !== 5'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: got v=%b cnt=%0d, want 0/0", m_desc_valid, cu_outstanding);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_limit();
    int grants = 0;
    int exp_grants;
`ifdef DMA_RD_ARB_LIMIT_EN
    exp_grants = 16;
`else
    exp_grants = 20;
`endif
    apply_reset();
    m_desc_ready = 1'b1;
    s_re_desc_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_re_desc_tag = 8'(k);
      #1;
      if (s_re_desc_ready === 1'b1) grants++;
      tick();
    end
    s_re_desc_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (grants !== exp_grants || re_outstanding !== 5'd16) begin
      failures++;
      $display("[TB] FAIL re_limit: got grants=%0d cnt=%0d, want %0d/16", grants, re_outstanding, exp_grants);
    end
    s_re_desc_valid = 1'b1;
    s_cu_desc_valid = 1'b1; s_cu_desc_tag = 8'h44;
    #1;
    checks++;
    if (s_cu_desc_ready !== 1'b1 || s_re_desc_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cu_bypass: got cu_rdy=%b re_rdy=%b, want 1/0", s_cu_desc_ready, s_re_desc_ready);
    end
    tick();
    s_cu_desc_valid = 1'b0; s_re_desc_valid = 1'b0;
    s_sts_valid = 1'b1; s_sts_tag = 9'h105; s_sts_error = 4'h3;
    tick();
    s_sts_valid = 1'b0;
    checks++;
    if (m_re_sts_valid !== 1'b1 || m_re_sts_tag !== 8'h05 || m_re_sts_error !== 4'h3
        || m_cu_sts_valid !== 1'b0 || re_outstanding !== 5'd15) begin
      failures++;
      $display("[TB] FAIL re_sts: got v=%b tag=%h err=%h cuv=%b cnt=%0d, want 1/05/3/0/15",
               m_re_sts_valid, m_re_sts_tag, m_re_sts_error, m_cu_sts_valid, re_outstanding);
    end
    s_re_desc_valid = 1'b1; s_re_desc_tag = 8'h77;
    #1;
    checks++;
    if (s_re_desc_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL re_unblock: got %b, want 1", s_re_desc_ready);
    end
    tick();
    s_re_desc_valid = 1'b0;
    checks++;
    if (m_desc_tag !== 9'h177) begin
      failures++;
      $display("[TB] FAIL re_unblock_tag: got %h, want 177", m_desc_tag);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    m_desc_ready = 1'b1;
    s_re_desc_valid = 1'b1; s_re_desc_tag = 8'h0A;
    tick();
    s_re_desc_valid = 1'b0;
    tick();
    s_re_desc_valid = 1'b1; s_re_desc_tag = 8'h0B;
    tick();
    s_re_desc_valid = 1'b0;
    s_sts_valid = 1'b1; s_sts_tag = 9'h10A;
    tick();
    s_sts_valid = 1'b0;
    checks++;
    if (re_outstanding !== 5'd1 || sts_underflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL inc_dec: got cnt=%0d uf=%b, want 1/0", re_outstanding, sts_underflow);
    end
    s_sts_valid = 1'b1; s_sts_tag = 9'h001;
    tick();
    s_sts_valid = 1'b0;
    checks++;
    if (sts_underflow !== 1'b1 || cu_outstanding !== 5'd0) begin
      failures++;
      $display("[TB] FAIL underflow: got uf=%b cnt=%0d, want 1/0", sts_underflow, cu_outstanding);
    end
    tick();
    checks++;
    if (sts_underflow !== 1'b1) begin
      failures++;
      $display("[TB] FAIL underflow_sticky: got %b, want 1", sts_underflow);
    end
  endtask

  task automatic test_afull();
    apply_reset();
    m_desc_ready = 1'b1;
    sel_afull = 1'b1;
    s_cu_desc_valid = 1'b1; s_cu_desc_tag = 8'h5A;
    s_re_desc_valid = 1'b1; s_re_desc_tag = 8'hA5;
    #1;
    checks++;
    if (s_cu_desc_ready !== 1'b0 || s_re_desc_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL afull_block: got rdy=%b%b, want 00", s_cu_desc_ready, s_re_desc_ready);
    end
    repeat (3) tick();
    checks++;
    if (m_desc_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL afull_idle: got v=%b, want 0", m_desc_valid);
    end
    sel_afull = 1'b0;
    #1;
    checks++;
    if (s_cu_desc_ready !== 1'b1 || s_re_desc_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL afull_resume: got rdy=%b%b, want 10", s_cu_desc_ready, s_re_desc_ready);
    end
    tick();
    sel_afull = 1'b1;
    checks++;
    if (m_desc_valid !== 1'b1 || sel_valid !== 1'b1 || m_desc_tag !== 9'h05A) begin
      failures++;
      $display("[TB] FAIL afull_grant: got v=%b sv=%b tag=%h, want 1/1/05A", m_desc_valid, sel_valid, m_desc_tag);
    end
    tick();
    checks++;
    if (m_desc_valid !== 1'b0 || cu_outstanding !== 5'd1) begin
      failures++;
      $display("[TB] FAIL afull_drain: got v=%b cnt=%0d, want 0/1", m_desc_valid, cu_outstanding);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_cu_stream();
    test_round_robin();
    test_backpressure();
    test_limit();
    test_same_cycle();
    test_afull();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
